// File: rtl/flash_controller.sv
// Bring-up sequencer for one ONFI NAND in async SDR mode: power-up wait, RESET, status poll, READ ID.
// Optional manufacturer-ID check on completion is enabled by defining FLASH_CTRL_ID_CHECK_EN.
module flash_controller #(
  parameter int unsigned T_PULSE    = 4,
  parameter int unsigned INIT_WAIT  = 100,
  parameter int unsigned T_WHR      = 8,
  parameter int unsigned T_WB       = 20,
  parameter int unsigned POLL_MAX   = 1000,
  parameter logic [7:0]  EXP_MFR_ID = 8'h2C
) (
  input  logic       CLK_sysClk,
  input  logic       RST_sysRst,
  inout  wire  [7:0] DQ,
  inout  wire        DQS,
  output logic       NAND_CLK,
  output logic       CLE,
  output logic       ALE,
  output logic       WRN,
  output logic       WPN,
  output logic [7:0] CEN,
  output logic [7:0] DEBUG,
  output logic [7:0] DEBUG90
);

  localparam int unsigned M1    = (INIT_WAIT > POLL_MAX) ? INIT_WAIT : POLL_MAX;
  localparam int unsigned M2    = (T_WB > T_WHR) ? T_WB : T_WHR;
  localparam int unsigned M3    = (M1 > M2) ? M1 : M2;
  localparam int unsigned MAX_P = (M3 > T_PULSE) ? M3 : T_PULSE;
  localparam int unsigned CW    = $clog2(MAX_P + 1);

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_ENABLE   = 4'd1,
    S_CMD_RST  = 4'd2,
    S_WAIT_WB  = 4'd3,
    S_POLL_CMD = 4'd4,
    S_POLL_WHR = 4'd5,
    S_POLL_RD  = 4'd6,
    S_ID_CMD   = 4'd7,
    S_ID_ADDR  = 4'd8,
    S_ID_WHR   = 4'd9,
    S_ID_RD    = 4'd10,
    S_DONE     = 4'd11,
    S_ERROR    = 4'd12
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] poll_cnt;
  logic          high_ph;
  logic [2:0]    byte_cnt;
  logic [7:0]    dq_out;
  logic          dq_oe;
  logic          done_f;
  logic          error_f;
  logic          id_ok_f;
`ifdef FLASH_CTRL_ID_CHECK_EN
  logic [7:0]    id_mfr;
`endif

  assign DQ    = dq_oe ? dq_out : 8'hzz;
  assign DQS   = 1'bz;
  assign DEBUG = {done_f, error_f, id_ok_f, 1'b0, state};

  // Sequencer: every bus cycle is T_PULSE low then T_PULSE high, tracked by cnt/high_ph
  always_ff @(posedge CLK_sysClk or posedge RST_sysRst) begin
    if (RST_sysRst) begin
      state    <= S_INIT;
      cnt      <= '0;
      poll_cnt <= '0;
      high_ph  <= 1'b0;
      byte_cnt <= '0;
      dq_out   <= '0;
      dq_oe    <= 1'b0;
      done_f   <= 1'b0;
      error_f  <= 1'b0;
      id_ok_f  <= 1'b0;
      NAND_CLK <= 1'b1;
      WRN      <= 1'b1;
      CLE      <= 1'b0;
      ALE      <= 1'b0;
      WPN      <= 1'b0;
      CEN      <= 8'hFF;
      DEBUG90  <= '0;
`ifdef FLASH_CTRL_ID_CHECK_EN
      id_mfr   <= '0;
`endif
    end else begin
      case (state)
        S_INIT: begin
          if (cnt == CW'(INIT_WAIT - 1)) begin
            state <= S_ENABLE;
            cnt   <= '0;
            CEN   <= 8'hFE;
            WPN   <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_ENABLE: begin
          state    <= S_CMD_RST;
          CLE      <= 1'b1;
          dq_out   <= 8'hFF;
          dq_oe    <= 1'b1;
          NAND_CLK <= 1'b0;
          cnt      <= '0;
        end

        S_CMD_RST, S_POLL_CMD, S_ID_CMD, S_ID_ADDR: begin
          if (cnt != CW'(T_PULSE - 1)) begin
            cnt <= cnt + CW'(1);
          end else if (!high_ph) begin
            NAND_CLK <= 1'b1;
            high_ph  <= 1'b1;
            cnt      <= '0;
          end else begin
            // Latch signals drop only once the high phase has completed
            cnt     <= '0;
            high_ph <= 1'b0;
            CLE     <= 1'b0;
            ALE     <= 1'b0;
            dq_oe   <= 1'b0;
            case (state)
              S_CMD_RST:  state <= S_WAIT_WB;
              S_POLL_CMD: state <= S_POLL_WHR;
              S_ID_CMD: begin
                state    <= S_ID_ADDR;
                ALE      <= 1'b1;
                dq_out   <= 8'h00;
                dq_oe    <= 1'b1;
                NAND_CLK <= 1'b0;
              end
              default:    state <= S_ID_WHR;
            endcase
          end
        end

        S_WAIT_WB: begin
          if (cnt == CW'(T_WB - 1)) begin
            state    <= S_POLL_CMD;
            CLE      <= 1'b1;
            dq_out   <= 8'h70;
            dq_oe    <= 1'b1;
            NAND_CLK <= 1'b0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_POLL_WHR, S_ID_WHR: begin
          if (cnt == CW'(T_WHR - 1)) begin
            state    <= (state == S_POLL_WHR) ? S_POLL_RD : S_ID_RD;
            WRN      <= 1'b0;
            byte_cnt <= '0;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_POLL_RD, S_ID_RD: begin
          if (cnt != CW'(T_PULSE - 1)) begin
            cnt <= cnt + CW'(1);
          end else if (!high_ph) begin
            // Sample on the last low cycle, then release RE_n
            WRN     <= 1'b1;
            high_ph <= 1'b1;
            cnt     <= '0;
            DEBUG90 <= DQ;
`ifdef FLASH_CTRL_ID_CHECK_EN
            if (state == S_ID_RD && byte_cnt == 3'd0) id_mfr <= DQ;
`endif
          end else begin
            cnt     <= '0;
            high_ph <= 1'b0;
            if (state == S_POLL_RD) begin
              poll_cnt <= poll_cnt + CW'(1);
              if (DEBUG90[6]) begin
                state    <= S_ID_CMD;
                CLE      <= 1'b1;
                dq_out   <= 8'h90;
                dq_oe    <= 1'b1;
                NAND_CLK <= 1'b0;
              end else if (poll_cnt == CW'(POLL_MAX - 1)) begin
                state   <= S_ERROR;
                CEN     <= 8'hFF;
                error_f <= 1'b1;
              end else begin
                state    <= S_POLL_CMD;
                CLE      <= 1'b1;
                dq_out   <= 8'h70;
                dq_oe    <= 1'b1;
                NAND_CLK <= 1'b0;
              end
            end else if (byte_cnt == 3'd4) begin
              CEN <= 8'hFF;
`ifdef FLASH_CTRL_ID_CHECK_EN
              if (id_mfr == EXP_MFR_ID) begin
                state   <= S_DONE;
                done_f  <= 1'b1;
                id_ok_f <= 1'b1;
              end else begin
                state   <= S_ERROR;
                error_f <= 1'b1;
              end
`else
              state  <= S_DONE;
              done_f <= 1'b1;
`endif
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
              WRN      <= 1'b0;
            end
          end
        end

        default: ;  // DONE and ERROR hold until reset
      endcase
    end
  end

endmodule

// File: tb/tb_flash_controller.sv
// Directed bench for flash_controller with a small reactive NAND model on DQ/WE_n/RE_n.
module tb_flash_controller;

  localparam int unsigned INIT_WAIT = 100;
  localparam int unsigned T_PULSE   = 4;
  localparam int unsigned POLL_MAX  = 4;

  logic       clk;
  logic       rst;
  wire  [7:0] dq;
  wire        dqs;
  logic       nand_clk, cle, ale, wrn, wpn;
  logic [7:0] cen, debug, debug90;

  int n_assert = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  flash_controller #(
    .T_PULSE(T_PULSE), .INIT_WAIT(INIT_WAIT), .T_WHR(8), .T_WB(20),
    .POLL_MAX(POLL_MAX), .EXP_MFR_ID(8'h2C)
  ) dut (
    .CLK_sysClk(clk), .RST_sysRst(rst), .DQ(dq), .DQS(dqs),
    .NAND_CLK(nand_clk), .CLE(cle), .ALE(ale), .WRN(wrn), .WPN(wpn),
    .CEN(cen), .DEBUG(debug), .DEBUG90(debug90)
  );

  // NAND model: logs latched bytes, answers status and ID reads
  logic [7:0] id_bytes [5] = '{8'h2C, 8'hDC, 8'h90, 8'h95, 8'h56};
  logic [9:0] wlog [16];
  logic [7:0] last_cmd;
  logic [7:0] model_data;
  int         log_n, status_reads, id_reads, overlap;
  int         busy_polls;

  always @(posedge nand_clk or posedge rst) begin
    if (rst) begin
      log_n    = 0;
      last_cmd = 8'h00;
    end else begin
      if (log_n < 16) wlog[log_n] = {cle, ale, dq};
      log_n = log_n + 1;
      if (cle) last_cmd = dq;
    end
  end

  always @(posedge wrn or posedge rst) begin
    if (rst) begin
      status_reads = 0;
      id_reads     = 0;
    end else if (last_cmd == 8'h70) begin
      status_reads = status_reads + 1;
    end else if (last_cmd == 8'h90) begin
      id_reads = id_reads + 1;
    end
  end

  always_comb begin
    model_data = 8'h00;
    if (last_cmd == 8'h70)
      model_data = (status_reads < busy_polls) ? 8'h80 : 8'hE0;
    else if (id_reads < 5)
      model_data = id_bytes[id_reads];
  end

  assign dq = wrn ? 8'hzz : model_data;

  initial overlap = 0;
  always @(negedge clk) if (!nand_clk && !wrn) overlap = overlap + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_nand_clk"}, 32'(nand_clk), 32'd1);
    check({tag, "_wrn"},      32'(wrn),      32'd1);
    check({tag, "_cle"},      32'(cle),      32'd0);
    check({tag, "_ale"},      32'(ale),      32'd0);
    check({tag, "_wpn"},      32'(wpn),      32'd0);
    check({tag, "_cen"},      32'(cen),      32'hFF);
    check({tag, "_debug"},    32'(debug),    32'h00);
    check({tag, "_debug90"},  32'(debug90),  32'h00);
  endtask

  // Release reset on a falling edge and count cycles with all chips deselected
  task automatic release_and_count(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    rst = 1'b0;
    check({tag, "_init_state"}, 32'(debug), 32'h00);
    while (cen == 8'hFF && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_init_cycles"},  32'(n),     32'(INIT_WAIT));
    check({tag, "_enable_cen"},   32'(cen),   32'hFE);
    check({tag, "_enable_wpn"},   32'(wpn),   32'd1);
    check({tag, "_enable_state"}, 32'(debug), 32'h01);
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(debug[7] || debug[6]) && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_end_reached"}, 32'(debug[7] || debug[6]), 32'd1);
  endtask

  logic [9:0] exp_log [7] = '{10'h2FF, 10'h270, 10'h270, 10'h270, 10'h270, 10'h290, 10'h100};
  logic [7:0] exp_done;
  int         lo, hi, n;

  initial begin
`ifdef FLASH_CTRL_ID_CHECK_EN
    exp_done = 8'hAB;
`else
    exp_done = 8'h8B;
`endif
    busy_polls = 3;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("por");

    // Run 1: busy for 3 polls, then ready; full ID read
    release_and_count("run1");
    n = 0;
    while (nand_clk && n < 100) begin n++; @(negedge clk); end
    check("rst_cmd_state", 32'(debug), 32'h02);
    check("rst_cmd_cle",   32'(cle),   32'd1);
    lo = 0;
    while (!nand_clk && lo < 50) begin lo++; @(negedge clk); end
    check("we_low_cycles", 32'(lo), 32'(T_PULSE));
    hi = 0;
    while (nand_clk && cle && hi < 50) begin hi++; @(negedge clk); end
    check("we_high_cycles", 32'(hi), 32'(T_PULSE));
    check("first_latch", 32'(wlog[0]), 32'h2FF);
    wait_end("run1");
    check("run1_log_n", 32'(log_n), 32'd7);
    for (int i = 0; i < 7; i++) check($sformatf("run1_log%0d", i), 32'(wlog[i]), 32'(exp_log[i]));
    check("run1_status_reads", 32'(status_reads), 32'd4);
    check("run1_id_reads",     32'(id_reads),     32'd5);
    check("run1_debug",        32'(debug),        32'(exp_done));
    check("run1_debug90",      32'(debug90),      32'h56);
    check("run1_cen",          32'(cen),          32'hFF);
    check("run1_wpn",          32'(wpn),          32'd1);

    // Run 2: status stuck busy -> timeout after POLL_MAX reads
    @(negedge clk);
    busy_polls = 1000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    release_and_count("run2");
    wait_end("run2");
    check("run2_debug",        32'(debug),        32'h4C);
    check("run2_cen",          32'(cen),          32'hFF);
    check("run2_status_reads", 32'(status_reads), 32'(POLL_MAX));
    check("run2_id_reads",     32'(id_reads),     32'd0);
    check("run2_debug90",      32'(debug90),      32'h80);
    check("run2_log_n",        32'(log_n),        32'd5);

    // Run 3: reset asserted mid ID read, then full restart
    @(negedge clk);
    busy_polls = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    release_and_count("run3a");
    n = 0;
    while (!(debug[3:0] == 4'd10 && !wrn) && n < 5000) begin n++; @(negedge clk); end
    check("run3_in_id_rd", 32'(debug[3:0] == 4'd10 && !wrn), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("midrd");
    repeat (2) @(negedge clk);
    release_and_count("run3b");
    wait_end("run3");
    check("run3_debug",        32'(debug),        32'(exp_done));
    check("run3_status_reads", 32'(status_reads), 32'd1);
    check("run3_id_reads",     32'(id_reads),     32'd5);
    check("run3_debug90",      32'(debug90),      32'h56);
    check("no_strobe_overlap", 32'(overlap),      32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
